mem_write_scheduler: RTL

MEM_WRITE_SCHEDULER -- requirements
Module: mem_write_scheduler

---
 rtl/mem_write_scheduler.sv | 124 ++++++++++++
 1 files changed

// File: rtl/mem_write_scheduler.sv
// Two-channel write scheduler: each decompressor channel buffers words in a small
// FIFO; a round-robin arbiter drains one word per ready cycle into a shared memory port.
module mem_write_scheduler #(
  parameter int N     = 32,
  parameter int AW    = 10,
  parameter int DEPTH = 4,
  parameter int BASE1 = 0,
  parameter int BASE2 = 512,
  parameter int SIZE  = 512
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          store1,
  input  logic          store2,
  input  logic [N-1:0]  data1,
  input  logic [N-1:0]  data2,
  output logic          full1,
  output logic          full2,
  output logic          ovf1,
  output logic          ovf2,
  input  logic          mem_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [N-1:0]  mem_wdata,
  output logic          mem_sel,
  output logic          busy
);

  // Handshakes: a storeX high at an edge with fullX low transfers dataX into the
  // channel buffer; storeX while fullX is high loses the word and sets ovfX.
  // A memory write is committed at every edge where mem_ready is high and a
  // buffer holds data; mem_we then stays high for exactly that following cycle.

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [N-1:0]  fifo_mem [2][DEPTH];
  logic [PW-1:0] wr_ptr [2];
  logic [PW-1:0] rd_ptr [2];
  logic [PW:0]   cnt [2];
  logic [AW-1:0] addr_ptr [2];
  logic [AW-1:0] base_addr [2];
  logic [AW-1:0] last_addr [2];
  logic [AW-1:0] next_addr [2];
  logic [N-1:0]  data_v [2];
  logic [1:0]    store_v, full_v, push, pop, ovf_q;
  logic          last_grant;
  logic          pop_ch;

  always_comb begin
    store_v      = {store2, store1};
    data_v[0]    = data1;
    data_v[1]    = data2;
    base_addr[0] = AW'(BASE1);
    base_addr[1] = AW'(BASE2);
    last_addr[0] = AW'(BASE1 + SIZE - 1);
    last_addr[1] = AW'(BASE2 + SIZE - 1);
    for (int c = 0; c < 2; c++) begin
      full_v[c]    = (cnt[c] == FULL_CNT);
      push[c]      = store_v[c] & ~full_v[c];
      next_addr[c] = (addr_ptr[c] == last_addr[c]) ? base_addr[c] : addr_ptr[c] + AW'(1);
    end
    // last_grant high means channel 2 was served last, so channel 1 has priority
    pop = 2'b00;
    if (mem_ready) begin
      if (cnt[0] != '0 && (cnt[1] == '0 || last_grant))
        pop[0] = 1'b1;
      else if (cnt[1] != '0)
        pop[1] = 1'b1;
    end
    pop_ch = pop[1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < 2; c++) begin
        cnt[c]      <= '0;
        wr_ptr[c]   <= '0;
        rd_ptr[c]   <= '0;
        addr_ptr[c] <= base_addr[c];
      end
      ovf_q      <= 2'b00;
      last_grant <= 1'b1;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_sel    <= 1'b0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (push[c]) begin
          fifo_mem[c][wr_ptr[c]] <= data_v[c];
          wr_ptr[c]              <= wr_ptr[c] + PW'(1);
        end
        if (pop[c]) begin
          rd_ptr[c]   <= rd_ptr[c] + PW'(1);
          addr_ptr[c] <= next_addr[c];
        end
        case ({push[c], pop[c]})
          2'b10:   cnt[c] <= cnt[c] + (PW+1)'(1);
          2'b01:   cnt[c] <= cnt[c] - (PW+1)'(1);
          default: cnt[c] <= cnt[c];
        endcase
        if (store_v[c] && full_v[c])
          ovf_q[c] <= 1'b1;
      end
      if (pop != 2'b00) begin
        mem_we     <= 1'b1;
        mem_sel    <= pop_ch;
        mem_addr   <= addr_ptr[pop_ch];
        mem_wdata  <= fifo_mem[pop_ch][rd_ptr[pop_ch]];
        last_grant <= pop_ch;
      end else begin
        mem_we <= 1'b0;
      end
    end
  end

  assign full1 = full_v[0];
  assign full2 = full_v[1];
  assign ovf1  = ovf_q[0];
  assign ovf2  = ovf_q[1];
  assign busy  = (cnt[0] != '0) | (cnt[1] != '0) | mem_we;

endmodule
